// File: rtl/logic_gates_bist_pkg.sv
// Shared definitions for the logic-gate BIST: FSM encoding, output bit order,
// error counter sizing and the golden truth-table function.
package logic_gates_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int GATE_W = 7;
    localparam int ERR_W  = 4;

    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_ZERO = '0;
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    // Bit positions of each gate in the packed 7-bit result word.
    localparam int BIT_AND  = 6;
    localparam int BIT_OR   = 5;
    localparam int BIT_NAND = 4;
    localparam int BIT_NOR  = 3;
    localparam int BIT_NOTB = 2;
    localparam int BIT_XOR  = 1;
    localparam int BIT_XNOR = 0;

    function automatic logic [GATE_W-1:0] golden_vec(input logic a, input logic b);
        logic [GATE_W-1:0] r;
        r           = '0;
        r[BIT_AND]  = a & b;
        r[BIT_OR]   = a | b;
        r[BIT_NAND] = ~(a & b);
        r[BIT_NOR]  = ~(a | b);
        r[BIT_NOTB] = ~b;
        r[BIT_XOR]  = a ^ b;
        r[BIT_XNOR] = ~(a ^ b);
        return r;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_ONE;
    endfunction

endpackage

// File: rtl/logic_gates_bist_gates.sv
// The gate block under test: seven basic two-input (and one single-input) gates.
module logic_gates (
    input  logic a,
    input  logic b,
    output logic and_out,
    output logic or_out,
    output logic nand_out,
    output logic nor_out,
    output logic notb_out,
    output logic xor_out,
    output logic xnor_out
);

    assign and_out  = a & b;
    assign or_out   = a | b;
    assign nand_out = ~(a & b);
    assign nor_out  = ~(a | b);
    assign notb_out = ~b;
    assign xor_out  = a ^ b;
    assign xnor_out = ~(a ^ b);

endmodule

// File: rtl/logic_gates_bist.sv
// Exhaustive 4-vector self-test of the logic_gates block, repeated PASSES times,
// reporting error count, first failing vector and the first failing bit mask.
module logic_gates_bist
    import logic_gates_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int PASSES      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] inj_mask,
    output logic              a_o,
    output logic              b_o,
    output logic              busy,
    output logic              done,
    output logic              pass_flag,
    output logic [ERR_W-1:0]  err_count,
    output logic [1:0]        fail_vec,
    output logic [GATE_W-1:0] fail_mask
);

    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] SWEEP_LAST = 3'(PASSES - 1);

    state_e             state_q;
    logic [1:0]         vec_q;
    logic [3:0]         hold_q;
    logic [2:0]         sweep_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [ERR_W-1:0]   err_q;
    logic [1:0]         fail_vec_q;
    logic [GATE_W-1:0]  fail_mask_q;

    logic [GATE_W-1:0]  gate_raw;
    logic [GATE_W-1:0]  golden_d;
    logic [GATE_W-1:0]  diff_d;
    logic               mismatch_d;
    logic [ERR_W-1:0]   err_inc_d;

    // Gates are driven straight from the registered vector so a_o/b_o and the
    // gate inputs always agree.
    logic_gates u_gates (
        .a        (vec_q[1]),
        .b        (vec_q[0]),
        .and_out  (gate_raw[BIT_AND]),
        .or_out   (gate_raw[BIT_OR]),
        .nand_out (gate_raw[BIT_NAND]),
        .nor_out  (gate_raw[BIT_NOR]),
        .notb_out (gate_raw[BIT_NOTB]),
        .xor_out  (gate_raw[BIT_XOR]),
        .xnor_out (gate_raw[BIT_XNOR])
    );

    assign golden_d = golden_vec(vec_q[1], vec_q[0]);

    generate
        for (genvar gi = 0; gi < GATE_W; gi++) begin : g_diff
            assign diff_d[gi] = gate_raw[gi] ^ inj_mask[gi] ^ golden_d[gi];
        end
    endgenerate

    assign mismatch_d = |diff_d;
    assign err_inc_d  = sat_inc(err_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= 2'd0;
            hold_q      <= 4'd0;
            sweep_q     <= 3'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= ERR_ZERO;
            fail_vec_q  <= 2'd0;
            fail_mask_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_APPLY;
                        busy_q      <= 1'b1;
                        vec_q       <= 2'd0;
                        hold_q      <= 4'd0;
                        sweep_q     <= 3'd0;
                        pass_q      <= 1'b0;
                        err_q       <= ERR_ZERO;
                        fail_vec_q  <= 2'd0;
                        fail_mask_q <= '0;
                    end
                end
                ST_APPLY: begin
                    if (hold_q == HOLD_LAST) begin
                        hold_q  <= 4'd0;
                        state_q <= ST_CHECK;
                    end else begin
                        hold_q <= hold_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch_d) begin
                        err_q <= err_inc_d;
                        if (err_q == ERR_ZERO) begin
                            fail_vec_q  <= vec_q;
                            fail_mask_q <= diff_d;
                        end
                    end
                    if (vec_q != 2'd3) begin
                        vec_q   <= vec_q + 2'd1;
                        state_q <= ST_APPLY;
                    end else if (sweep_q != SWEEP_LAST) begin
                        vec_q   <= 2'd0;
                        sweep_q <= sweep_q + 3'd1;
                        state_q <= ST_APPLY;
                    end else begin
                        // The final compare lands in err_q on this same edge,
                        // so the verdict must fold it in directly.
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == ERR_ZERO) && !mismatch_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_o       = vec_q[1];
    assign b_o       = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_flag = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_logic_gates_bist.sv
// Directed scoreboard bench for logic_gates_bist: a default-parameter instance
// and a PASSES=4 / HOLD_CYCLES=1 instance driven through a sequence of runs.
module tb_logic_gates_bist;

    logic       clk;
    logic       rst;
    logic       start1, start4;
    logic [6:0] inj1, inj4;

    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [1:0] fv1;
    logic [6:0] fm1;

    logic       a4, b4, busy4, done4, pass4;
    logic [3:0] err4;
    logic [1:0] fv4;
    logic [6:0] fm4;

    logic       sel;
    logic       obs_busy, obs_done, obs_pass;
    logic [1:0] obs_vec, obs_fv;
    logic [3:0] obs_err;
    logic [6:0] obs_fm;
    logic [17:0] obs_all;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] err;
        logic [1:0] fv;
        logic [6:0] fm;
        logic       pass;
    } res_t;

    logic [1:0] vec_sb[$];
    res_t       res_sb[$];

    logic_gates_bist dut1 (
        .clk(clk), .rst(rst), .start(start1), .inj_mask(inj1),
        .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass_flag(pass1),
        .err_count(err1), .fail_vec(fv1), .fail_mask(fm1)
    );

    logic_gates_bist #(.HOLD_CYCLES(1), .PASSES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .inj_mask(inj4),
        .a_o(a4), .b_o(b4), .busy(busy4), .done(done4), .pass_flag(pass4),
        .err_count(err4), .fail_vec(fv4), .fail_mask(fm4)
    );

    assign obs_busy = sel ? busy4 : busy1;
    assign obs_done = sel ? done4 : done1;
    assign obs_pass = sel ? pass4 : pass1;
    assign obs_vec  = sel ? {a4, b4} : {a1, b1};
    assign obs_fv   = sel ? fv4 : fv1;
    assign obs_err  = sel ? err4 : err1;
    assign obs_fm   = sel ? fm4 : fm1;
    assign obs_all  = {obs_vec, obs_busy, obs_done, obs_pass, obs_err, obs_fv, obs_fm};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start4 = v; else start1 = v;
    endtask

    task automatic set_inj(input logic [6:0] v);
        if (sel) inj4 = v; else inj1 = v;
    endtask

    // One run: tgt_chk selects which CHECK (counted from 0 across all passes)
    // sees inj_tgt instead of inj_all; rst_at >= 0 aborts on that busy cycle.
    task automatic do_run(input string name, input logic s, input int passes, input int hold,
                          input logic [6:0] inj_all, input int tgt_chk, input logic [6:0] inj_tgt,
                          input int rst_at, input bit pokes);
        int   total;
        int   nerr;
        int   ci;
        bit   on_check;
        logic [6:0] ic;
        logic [1:0] kv;
        res_t r;
        res_t got;

        sel   = s;
        total = passes * 4 * (hold + 1);
        nerr  = 0;
        r.fv  = 2'd0;
        r.fm  = 7'd0;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < 4; k++) begin
                kv = 2'(k);
                ic = ((p * 4 + k) == tgt_chk) ? inj_tgt : inj_all;
                for (int h = 0; h <= hold; h++) vec_sb.push_back(kv);
                if (ic != 7'd0) begin
                    if (nerr == 0) begin
                        r.fv = kv;
                        r.fm = ic;
                    end
                    nerr++;
                end
            end
        end
        r.err  = (nerr > 15) ? 4'd15 : 4'(nerr);
        r.pass = (nerr == 0);
        if (rst_at < 0) res_sb.push_back(r);

        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);

        for (int c = 0; c < total; c++) begin
            ci       = c / (hold + 1);
            on_check = ((c % (hold + 1)) == hold);
            set_inj((on_check && ci == tgt_chk) ? inj_tgt : inj_all);
            set_start(pokes && (c % 3 == 1));
            if (c == rst_at) rst = 1'b1;
            @(negedge clk);
            chk({name, " busy"}, 32'(obs_busy), 32'd1);
            chk({name, " done_early"}, 32'(obs_done), 32'd0);
            chk({name, " vec"}, 32'(obs_vec), 32'(vec_sb.pop_front()));
            if (c == rst_at) begin
                @(posedge clk);
                #1;
                rst = 1'b0;
                set_inj(7'd0);
                set_start(1'b0);
                @(negedge clk);
                chk({name, " reset_outputs"}, 32'(obs_all), 32'd0);
                vec_sb.delete();
                for (int w = 0; w < 6; w++) begin
                    @(negedge clk);
                    chk({name, " no_done_after_abort"}, 32'({obs_busy, obs_done}), 32'd0);
                end
                $display("run %s: aborted at busy cycle %0d", name, rst_at);
                return;
            end
            @(posedge clk);
            #1;
        end
        set_inj(7'd0);
        set_start(1'b0);

        @(negedge clk);
        got = res_sb.pop_front();
        chk({name, " done"}, 32'(obs_done), 32'd1);
        chk({name, " busy_end"}, 32'(obs_busy), 32'd0);
        chk({name, " err_count"}, 32'(obs_err), 32'(got.err));
        chk({name, " fail_vec"}, 32'(obs_fv), 32'(got.fv));
        chk({name, " fail_mask"}, 32'(obs_fm), 32'(got.fm));
        chk({name, " pass_flag"}, 32'(obs_pass), 32'(got.pass));
        @(negedge clk);
        chk({name, " done_pulse_width"}, 32'(obs_done), 32'd0);
        chk({name, " idle_hold"}, 32'({obs_vec, obs_busy, obs_pass}), 32'({2'b11, 1'b0, got.pass}));
        $display("run %s: busy=%0d err=%0d fail_vec=%b fail_mask=%b pass=%0d",
                 name, total, obs_err, obs_fv, obs_fm, obs_pass);
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        inj1   = 7'd0;
        inj4   = 7'd0;
        sel    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_dut1", 32'({a1, b1, busy1, done1, pass1, err1, fv1, fm1}), 32'd0);
        chk("reset_dut4", 32'({a4, b4, busy4, done4, pass4, err4, fv4, fm4}), 32'd0);

        do_run("clean",     1'b0, 1, 2, 7'd0,        -1, 7'd0,        -1, 1'b0);
        do_run("inj_notb",  1'b0, 1, 2, 7'b0000100,  -1, 7'd0,        -1, 1'b0);
        do_run("inj_and10", 1'b0, 1, 2, 7'd0,         2, 7'b1000000,  -1, 1'b0);
        do_run("saturate",  1'b1, 4, 1, 7'h7F,       -1, 7'd0,        -1, 1'b0);
        do_run("abort",     1'b0, 1, 2, 7'd0,        -1, 7'd0,         4, 1'b0);
        do_run("post_abort",1'b0, 1, 2, 7'd0,        -1, 7'd0,        -1, 1'b0);
        do_run("pokes",     1'b0, 1, 2, 7'b0000001,  -1, 7'd0,        -1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
